weight_update_engine: RTL and testbench
=======================================

WEIGHT_UPDATE_ENGINE -- requirements
Module: weight_update_engine

Interface
REQ-001 Parameter NUM_INPUTS, default 32: number of dendrite inputs; the weight vector holds NUM_INPUTS+1 entries, and the last entry is the bias.
REQ-002 Parameter WIDTH, default 32: bit width of each dendrite, weight, error and rate operand.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port wu_clock, in, 1: the only clock; all state updates on its rising edge.
REQ-005 Port wu_resetn, in, 1: synchronous active-low reset.
REQ-006 Port wu_start, in, 1: request one training pass; sampled only in IDLE.
REQ-007 Port wu_dendrites, in, [NUM_INPUTS-1:0][WIDTH-1:0]: signed dendrite values for the pass.
REQ-008 Port wu_error, in, WIDTH: signed backpropagated error for this neuron.
REQ-009 Port wu_trainingMul, in, WIDTH: unsigned learning-rate numerator.
REQ-010 Port wu_trainingDiv, in, WIDTH: unsigned learning-rate denominator.
REQ-011 Port wu_weights, out, [NUM_INPUTS:0][WIDTH-1:0]: registered signed weights; index NUM_INPUTS is the bias.
REQ-012 Port wu_busy, out, 1: high in states UPDATE and DONE.
REQ-013 Port wu_done, out, 1: one-cycle pulse that marks the end of a pass.
REQ-014 Port wu_divErr, out, 1: high together with wu_done when the pass ran with wu_trainingDiv==0.

Function
REQ-015 The FSM SHALL have three states: IDLE, UPDATE and DONE.
- IDLE→UPDATE on wu_start=1.
- UPDATE→DONE after index NUM_INPUTS is processed.
- DONE→IDLE unconditionally after one cycle.
REQ-016 On the IDLE edge that accepts wu_start, the block SHALL:
- latch wu_dendrites, wu_error, wu_trainingMul and wu_trainingDiv into internal registers;
- clear index idx to 0.
REQ-017 Input changes after that latching edge SHALL have no effect on the current pass.
REQ-018 Each UPDATE edge SHALL update exactly one weight, weights[idx], then increment idx; all other weights hold.
REQ-019 The operand x SHALL be the latched dendrite[idx] for idx<NUM_INPUTS, and the constant 1 for idx==NUM_INPUTS (bias).
REQ-020 The weight delta SHALL be computed as follows:
- delta = (error*x*mul)/div.
- Full-precision signed product, at least 3*WIDTH+1 bits.
- Division truncates toward zero.
- The quotient saturates to the signed WIDTH range.
REQ-021 The new weight SHALL be weights[idx]+delta, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; it SHALL never wrap.
REQ-022 If the latched div==0, delta SHALL be 0 for every index, and wu_divErr SHALL assert in DONE.
REQ-023 Latency: with start accepted at edge E0, the updates occur on edges E1..E(NUM_INPUTS+1).
- wu_done=1 for the single cycle after E(NUM_INPUTS+1) (33 cycles after E0 at default).
- IDLE resumes at the following edge.
REQ-024 wu_start SHALL be ignored while wu_busy=1; back-to-back passes SHALL be possible with start high on the first IDLE cycle.
REQ-025 wu_weights SHALL be driven directly from the weight registers and stay stable except on UPDATE edges.
REQ-026 wu_done and wu_divErr SHALL be 0 in all states other than DONE.

Reset
REQ-027 When wu_resetn=0 at a rising edge, the block SHALL:
- clear all weights to 0;
- set state to IDLE and idx to 0;
- drive wu_busy, wu_done and wu_divErr to 0.
REQ-028 Reset SHALL take priority over wu_start and over any state, including mid-pass; a partially updated weight vector SHALL be cleared, not retained.
REQ-029 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Verification
REQ-030 Reset: hold wu_resetn low for 2 cycles -> all 33 weights 0; busy=0, done=0, divErr=0.
REQ-031 Basic pass: x[0]=3, other x=0, error=4, mul=1, div=2, start 1 cycle -> done exactly 33 cycles after the start edge; w[0]=6, w[32]=2, others 0.
REQ-032 Truncation: from reset, x[1]=1, error=-3, mul=1, div=2 -> w[1]=-1, w[32]=-1 (not -2).
REQ-033 Saturation: x[0]=4, error=2^30, mul=1, div=1.
- After pass 1: w[0]=0x7FFFFFFF.
- After a second identical pass: w[0] still 0x7FFFFFFF.
REQ-034 Divide-by-zero: div=0, error=5, x[0]=7 -> all weights unchanged; divErr=1 only in the done cycle.
REQ-035 Interference, two cases:
- Pulse start and change all inputs at idx=10 -> result identical to the undisturbed pass.
- Pull wu_resetn low at idx=10 -> all weights 0 and IDLE on the next cycle, with no done pulse.

Source files
------------

// File: rtl/weight_update_engine.sv
// Weight update engine: applies one training pass to a neuron's weight vector.
// Each pass latches the dendrites, error and learning rate, then updates one
// weight per clock: w[i] += sat((error * x[i] * mul) / div), saturating the sum.
// The final entry is the bias, whose operand is the constant 1.
module weight_update_engine #(
    parameter int NUM_INPUTS = 32,
    parameter int WIDTH      = 32
) (
    input  logic                                wu_clock,
    input  logic                                wu_resetn,
    input  logic                                wu_start,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    wu_dendrites,
    input  logic [WIDTH-1:0]                    wu_error,
    input  logic [WIDTH-1:0]                    wu_trainingMul,
    input  logic [WIDTH-1:0]                    wu_trainingDiv,
    output logic [NUM_INPUTS:0][WIDTH-1:0]      wu_weights,
    output logic                                wu_busy,
    output logic                                wu_done,
    output logic                                wu_divErr
);

    localparam int IDX_W = $clog2(NUM_INPUTS + 1);
    // Product width: signed error * signed x * unsigned rate, plus sign headroom.
    localparam int PW    = 3 * WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS);
    localparam logic [WIDTH-1:0] W_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] W_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                         state_r;
    logic [IDX_W-1:0]               idx_r;
    logic [NUM_INPUTS:0][WIDTH-1:0] weights_r;
    // Latched operands; the top entry is preloaded with 1 so the bias uses the same path.
    logic [NUM_INPUTS:0][WIDTH-1:0] ops_r;
    logic [WIDTH-1:0]               err_r;
    logic [WIDTH-1:0]               mul_r;
    logic [WIDTH-1:0]               div_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           div_err_r;

    logic signed [PW-1:0]           err_ext_s;
    logic signed [PW-1:0]           x_ext_s;
    logic signed [PW-1:0]           mul_ext_s;
    logic signed [PW-1:0]           div_ext_s;
    logic signed [PW-1:0]           prod_s;
    logic signed [PW-1:0]           quot_s;
    logic [WIDTH-1:0]               x_s;
    logic [WIDTH-1:0]               delta_s;
    logic [WIDTH-1:0]               new_w_s;

    // Clamp a full-precision signed quotient into the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat_quotient(input logic signed [PW-1:0] q);
        logic signed [PW-1:0] q_max;
        logic signed [PW-1:0] q_min;
        q_max = {{(PW-WIDTH){1'b0}}, W_MAX};
        q_min = {{(PW-WIDTH){1'b1}}, W_MIN};
        if (q > q_max) begin
            return W_MAX;
        end else if (q < q_min) begin
            return W_MIN;
        end else begin
            return q[WIDTH-1:0];
        end
    endfunction

    // Signed WIDTH-bit add that clamps instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? W_MIN : W_MAX;
        end else begin
            return s[WIDTH-1:0];
        end
    endfunction

    // Delta and saturated new value for the weight currently addressed by idx_r.
    always_comb begin
        x_s       = ops_r[idx_r];
        err_ext_s = {{(PW-WIDTH){err_r[WIDTH-1]}}, err_r};
        x_ext_s   = {{(PW-WIDTH){x_s[WIDTH-1]}}, x_s};
        mul_ext_s = {{(PW-WIDTH){1'b0}}, mul_r};
        div_ext_s = {{(PW-WIDTH){1'b0}}, div_r};
        prod_s    = err_ext_s * x_ext_s * mul_ext_s;
        // A zero rate denominator turns the whole pass into a no-op.
        if (div_r != {WIDTH{1'b0}}) begin
            quot_s = prod_s / div_ext_s;
        end else begin
            quot_s = {PW{1'b0}};
        end
        delta_s = sat_quotient(quot_s);
        new_w_s = sat_add(weights_r[idx_r], delta_s);
    end

    // Pass sequencer: operand latching, one weight write per UPDATE cycle, status flags.
    always_ff @(posedge wu_clock) begin
        if (!wu_resetn) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IDX_W{1'b0}};
            weights_r <= '0;
            ops_r     <= '0;
            err_r     <= {WIDTH{1'b0}};
            mul_r     <= {WIDTH{1'b0}};
            div_r     <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            div_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    div_err_r <= 1'b0;
                    if (wu_start) begin
                        ops_r   <= {W_ONE, wu_dendrites};
                        err_r   <= wu_error;
                        mul_r   <= wu_trainingMul;
                        div_r   <= wu_trainingDiv;
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_UPDATE;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    weights_r[idx_r] <= new_w_s;
                    if (idx_r == LAST_IDX) begin
                        done_r    <= 1'b1;
                        div_err_r <= (div_r == {WIDTH{1'b0}});
                        state_r   <= ST_DONE;
                    end else begin
                        idx_r     <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    done_r    <= 1'b0;
                    div_err_r <= 1'b0;
                    busy_r    <= 1'b0;
                    idx_r     <= {IDX_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
                default: begin
                    done_r    <= 1'b0;
                    div_err_r <= 1'b0;
                    busy_r    <= 1'b0;
                    idx_r     <= {IDX_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign wu_weights = weights_r;
    assign wu_busy    = busy_r;
    assign wu_done    = done_r;
    assign wu_divErr  = div_err_r;

endmodule

// File: tb/tb_weight_update_engine.sv
// Self-checking bench for weight_update_engine: directed table, hand-written
// corner sequences and randomized passes against an arithmetic reference model.
module tb_weight_update_engine;

    localparam int NI = 32;
    localparam int W  = 32;
    localparam int NW = NI + 1;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    start = 1'b0;
    logic [NI-1:0][W-1:0]    dend = '0;
    logic [W-1:0]            err = '0;
    logic [W-1:0]            mul = '0;
    logic [W-1:0]            dv = '0;
    logic [NI:0][W-1:0]      weights;
    logic                    busy;
    logic                    done;
    logic                    div_err;

    int tests = 0;
    int fails = 0;
    longint m_w[NW];

    always #5 clk = ~clk;

    weight_update_engine #(.NUM_INPUTS(NI), .WIDTH(W)) dut (
        .wu_clock       (clk),
        .wu_resetn      (resetn),
        .wu_start       (start),
        .wu_dendrites   (dend),
        .wu_error       (err),
        .wu_trainingMul (mul),
        .wu_trainingDiv (dv),
        .wu_weights     (weights),
        .wu_busy        (busy),
        .wu_done        (done),
        .wu_divErr      (div_err)
    );

    typedef struct {
        bit          rst;
        logic [W-1:0] x0, x1, e, m, d;
        logic [W-1:0] w0, w1, w32;
    } vec_t;

    vec_t tbl[7];

    function automatic longint clamp(input logic signed [127:0] v);
        if (v > 128'sd2147483647) return 64'sd2147483647;
        else if (v < -128'sd2147483648) return -64'sd2147483648;
        else return longint'(v[63:0]);
    endfunction

    // Reference: every weight gets clamp(w + clamp(e*x*m/d)), bias operand is 1.
    task automatic model_pass(input logic [NI-1:0][W-1:0] d, input logic [W-1:0] e,
                              input logic [W-1:0] m, input logic [W-1:0] dd);
        for (int i = 0; i < NW; i++) begin
            logic signed [127:0] x, p, q;
            if (i < NI) x = $signed(d[i]);
            else        x = 128'sd1;
            p = $signed(e) * x * $signed({96'd0, m});
            if (dd == 32'd0) q = 128'sd0;
            else             q = p / $signed({96'd0, dd});
            m_w[i] = clamp(128'(m_w[i]) + 128'(clamp(q)));
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) m_w[i] = 0;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_weights(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < NW; i++)
            if (longint'($signed(weights[i])) != m_w[i] && bad < 0) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: w[%0d] got %0d expected %0d", name, bad,
                     longint'($signed(weights[bad])), m_w[bad]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_clear();
        check_weights("reset_weights");
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diverr", div_err, 0);
    endtask

    function automatic logic [W-1:0] rnd_small();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 2000)) - 32'd1000;
        return v;
    endfunction

    // One pass from IDLE; optionally scrambles all inputs and re-pulses start at idx 10.
    task automatic run_pass(input string name, input logic [NI-1:0][W-1:0] d,
                            input logic [W-1:0] e, input logic [W-1:0] m,
                            input logic [W-1:0] dd, input bit disturb);
        int cyc;
        bit got_done, early;
        @(negedge clk);
        dend = d; err = e; mul = m; dv = dd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        cyc = 0; got_done = 0; early = 0;
        while (cyc < 100 && !got_done) begin
            if (disturb && cyc == 10) begin
                for (int i = 0; i < NI; i++) dend[i] = $urandom;
                err = $urandom; mul = $urandom; dv = $urandom; start = 1'b1;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) got_done = 1;
            else if (div_err) early = 1;
        end
        check({name, "_latency"}, cyc, 33);
        check({name, "_diverr"}, div_err, (dd == 32'd0) ? 1 : 0);
        check({name, "_no_early_flag"}, early, 0);
        model_pass(d, e, m, dd);
        check_weights({name, "_weights"});
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_flags"}, {done, div_err}, 0);
    endtask

    initial begin
        logic [NI-1:0][W-1:0] d;
        logic [W-1:0] e, m, dd;
        int cyc, nd;
        int dcyc[2];
        bit bad_flag;

        tbl[0] = '{1'b1, 32'd3, 32'd0, 32'd4, 32'd1, 32'd2, 32'd6, 32'd0, 32'd2};
        tbl[1] = '{1'b1, 32'd0, 32'd1, 32'hFFFFFFFD, 32'd1, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[2] = '{1'b1, 32'd4, 32'd0, 32'h40000000, 32'd1, 32'd1, 32'h7FFFFFFF, 32'd0, 32'h40000000};
        tbl[3] = '{1'b0, 32'd4, 32'd0, 32'h40000000, 32'd1, 32'd1, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF};
        tbl[4] = '{1'b0, 32'd7, 32'd0, 32'd5, 32'd1, 32'd0, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF};
        tbl[5] = '{1'b1, 32'hFFFFFFFC, 32'd0, 32'h40000000, 32'd1, 32'd1, 32'h80000000, 32'd0, 32'h40000000};
        tbl[6] = '{1'b1, 32'd5, 32'hFFFFFFFE, 32'd3, 32'd7, 32'd4, 32'd26, 32'hFFFFFFF6, 32'd5};

        do_reset();

        // Directed table.
        for (int t = 0; t < 7; t++) begin
            if (tbl[t].rst) do_reset();
            d = '0;
            d[0] = tbl[t].x0;
            d[1] = tbl[t].x1;
            run_pass($sformatf("vec%0d", t), d, tbl[t].e, tbl[t].m, tbl[t].d, 1'b0);
            check($sformatf("vec%0d_w0", t),  $signed(weights[0]),  $signed(tbl[t].w0));
            check($sformatf("vec%0d_w1", t),  $signed(weights[1]),  $signed(tbl[t].w1));
            check($sformatf("vec%0d_w32", t), $signed(weights[32]), $signed(tbl[t].w32));
        end

        // Inputs scrambled and start re-pulsed mid-pass: result follows latched operands.
        do_reset();
        for (int i = 0; i < NI; i++) d[i] = rnd_small();
        e = rnd_small(); m = W'($urandom_range(1, 9)); dd = W'($urandom_range(1, 9));
        run_pass("disturb", d, e, m, dd, 1'b1);

        // Reset mid-pass at idx 10: cleared vector, IDLE, no done pulse.
        do_reset();
        run_pass("pre_abort", d, e, m, dd, 1'b0);
        @(negedge clk);
        for (int i = 0; i < NI; i++) dend[i] = rnd_small();
        err = rnd_small(); mul = 32'd3; dv = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_clear();
        check_weights("abort_weights");
        check("abort_busy", busy, 0);
        bad_flag = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div_err || busy) bad_flag = 1;
        end
        check("abort_no_done", bad_flag, 0);
        run_pass("post_abort", d, e, m, dd, 1'b0);

        // Back-to-back: start held high, second pass begins on the first IDLE cycle.
        do_reset();
        for (int i = 0; i < NI; i++) d[i] = rnd_small();
        e = rnd_small(); m = 32'd2; dd = 32'd3;
        @(negedge clk);
        dend = d; err = e; mul = m; dv = dd; start = 1'b1;
        @(negedge clk);
        cyc = 0; nd = 0; dcyc[0] = 0; dcyc[1] = 0;
        while (cyc < 150 && nd < 2) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dcyc[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_first_done", dcyc[0], 33);
        check("b2b_second_done", dcyc[1], 68);
        model_pass(d, e, m, dd);
        model_pass(d, e, m, dd);
        check_weights("b2b_weights");
        @(negedge clk);

        // Randomized passes against the reference model.
        for (int r = 0; r < 10; r++) begin
            int mode;
            if ($urandom_range(0, 2) == 0) do_reset();
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NI; i++) d[i] = (mode == 1) ? W'($urandom) : rnd_small();
            e  = (mode == 1) ? W'($urandom) : rnd_small();
            m  = (mode == 2) ? W'($urandom_range(1, 100000)) : W'($urandom_range(0, 10));
            dd = (mode == 1) ? W'($urandom) : W'($urandom_range(0, 12));
            run_pass($sformatf("rand%0d", r), d, e, m, dd, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
